// File: rtl/mem_stage.sv
// Memory pipeline stage: issues BRAM load/store for an executed instruction and
// registers the writeback result. Define MEM_ADDR_CHECK_EN to trap bad addresses.
module mem_stage #(
    parameter int INST_SIZE = 10,
    parameter int BRAM_SIZE = 18
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_SIZE-1:0] pc,
    input  logic [4:0]           rd,
    input  logic                 wb_en,
    input  logic [31:0]          d,
    input  logic [31:0]          t,
    input  logic                 rea,
    input  logic                 wea,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [BRAM_SIZE-1:0] mem_addr,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INST_SIZE-1:0] out_pc,
    output logic [4:0]           out_rd,
    output logic                 out_wb_en,
    output logic [31:0]          out_data,
    output logic                 addr_err
);

    typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;

    state_t               state;
    logic                 accept;
    logic                 addr_bad;
    logic                 err_q;
    logic [INST_SIZE-1:0] pend_pc;
    logic [4:0]           pend_rd;
    logic                 pend_wb;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign addr_err = err_q;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad = (rea || wea) &&
                      ((d[1:0] != 2'b00) || (d[31:BRAM_SIZE+2] != '0));
`else
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, d[1:0], d[31:BRAM_SIZE+2]};
    assign addr_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_rd    <= '0;
            out_wb_en <= 1'b0;
            out_data  <= '0;
            err_q     <= 1'b0;
            pend_pc   <= '0;
            pend_rd   <= '0;
            pend_wb   <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_addr <= d[BRAM_SIZE+1:2];
                        mem_din  <= t;
                        // rea wins over wea: a combined request is a plain load
                        if (rea && !addr_bad) begin
                            state   <= RD1;
                            mem_en  <= 1'b1;
                            pend_pc <= pc;
                            pend_rd <= rd;
                            pend_wb <= wb_en;
                        end else begin
                            out_valid <= 1'b1;
                            out_pc    <= pc;
                            out_rd    <= rd;
                            out_wb_en <= wb_en && !addr_bad;
                            out_data  <= addr_bad ? 32'd0 : d;
                            err_q     <= addr_bad;
                            if (wea && !addr_bad) begin
                                mem_en <= 1'b1;
                                mem_we <= 1'b1;
                            end
                        end
                    end
                end
                RD1: state <= RD2;
                RD2: begin
                    // read data is valid in the cycle after the enable
                    state     <= IDLE;
                    out_valid <= 1'b1;
                    out_pc    <= pend_pc;
                    out_rd    <= pend_rd;
                    out_wb_en <= pend_wb;
                    out_data  <= mem_dout;
                    err_q     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
